// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debounce slice.
package debounce_pkg;

  typedef enum logic [1:0] {ST_LO, WAIT_HI, ST_HI, WAIT_LO} debounce_state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;
  localparam int unsigned SYNC_DEFAULT     = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level; clears on synchronous reset.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronizes a bouncing raw level, accepts a new level only after DEBOUNCE_CYCLES stable
// samples, and emits registered level plus one-cycle rise/fall pulses.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync;
  debounce_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_d, rise_d, fall_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (raw_in),
    .q    (sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LO: begin
        out_d = 1'b0;
        if (sync) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        out_d = 1'b0;
        if (!sync) begin
          // Bounce rejected before the level proved stable.
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = ST_HI;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        out_d = 1'b1;
        if (!sync) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        out_d = 1'b1;
        if (sync) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = ST_LO;
          cnt_d   = '0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      out     <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

endmodule
